mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles WAIT holds before abandoning an access; 0 disables the timeout.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 alu_result  in  32  byte address from EX/MEM.
REQ-005 writedata  in  32  store data from EX/MEM.
REQ-006 memread, memwrite  in  1 each  load / store request from EX/MEM; never both high.
REQ-007 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 is_unsigned  in  1  zero-extend loads when high, sign-extend when low.
REQ-009 branch, zero  in  1 each  branch control and ALU zero flag from EX/MEM.
REQ-010 dmem_req  out  1  registered bus request.
REQ-011 dmem_we  out  1  registered write enable.
REQ-012 dmem_addr  out  32  registered word address, alu_result with bits [1:0] cleared.
REQ-013 dmem_wdata  out  32  registered, lane-replicated store data.
REQ-014 dmem_be  out  4  registered byte enables.
REQ-015 dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle.
REQ-016 dmem_rdata  in  32  read word.
REQ-017 load_data  out  32  registered, extended load result for MEM/WB.
REQ-018 stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-019 pcsrc  out  1  combinational branch-taken select.
REQ-020 misalign_err  out  1  registered one-cycle pulse.
REQ-021 bus_err  out  1  registered one-cycle pulse.

Function
REQ-022 pcsrc SHALL equal branch AND zero in every state.
REQ-023 The block SHALL implement the states IDLE, WAIT and DONE.
REQ-024 A memory operation (memread or memwrite) SHALL be legal when size is 00, when size is 01 with alu_result[0]=0, or when size is 10 with alu_result[1:0]=00.
REQ-025 IDLE with a legal operation: next edge loads dmem_addr/wdata/be/we, sets dmem_req=1, moves to WAIT and clears the timeout counter.
REQ-026 IDLE with an illegal operation: next edge pulses misalign_err, issues no bus request and stays in IDLE.
REQ-027 Byte store: dmem_be = 0001 shifted left by alu_result[1:0]; dmem_wdata = writedata[7:0] replicated ×4.
REQ-028 Half store: dmem_be = 0011 if alu_result[1]=0, else 1100; dmem_wdata = writedata[15:0] replicated ×2.
REQ-029 Word store: dmem_be = 1111; dmem_wdata = writedata.
REQ-030 Loads SHALL drive dmem_be = 1111 and dmem_we = 0.
REQ-031 WAIT: dmem_req and all bus outputs SHALL hold stable until dmem_ack.
REQ-032 On dmem_ack in WAIT: next edge deasserts dmem_req, moves to DONE and, for loads, registers into load_data the byte/half selected by the latched address offset, extended per is_unsigned; stores leave load_data unchanged.
REQ-033 dmem_ack SHALL be ignored in IDLE and DONE.
REQ-034 When TIMEOUT>0 and WAIT has lasted TIMEOUT cycles without ack: next edge drops dmem_req, pulses bus_err, clears load_data to 0 and moves to DONE.
REQ-035 stall SHALL be 1 in IDLE with a legal operation and in WAIT, and 0 otherwise.
REQ-036 Minimum load/store latency SHALL be 3 cycles (IDLE, WAIT with same-cycle ack, DONE), with stall high for the first two.
REQ-037 DONE SHALL return to IDLE unconditionally after one cycle and SHALL NOT reissue the operation still presented on its inputs.
REQ-038 Back-to-back operations SHALL each be accepted from IDLE on the cycle after DONE.

Reset
REQ-039 Reset SHALL force IDLE and zero every registered output (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, load_data, misalign_err, bus_err) and the timeout counter.
REQ-040 Reset during WAIT SHALL drop dmem_req on that edge; a late dmem_ack SHALL then be ignored.

Verification
REQ-041 LB: addr 0x1003, rdata 0x80FF_FF01, ack on the first WAIT cycle -> load_data 0xFFFF_FF80; stall high for exactly 2 cycles.
REQ-042 LHU: addr 0x2002, rdata 0xBEEF_1234 -> load_data 0x0000_BEEF.
REQ-043 SB: addr 0x0101, writedata 0x0000_00AB -> dmem_be 0010, dmem_wdata 0xABAB_ABAB, dmem_we 1, dmem_addr 0x0100.
REQ-044 LW at addr 0x0006 -> misalign_err pulses once, dmem_req never asserts, stall stays 0.
REQ-045 TIMEOUT=4, no ack -> dmem_req high for 4 cycles, then a bus_err pulse, load_data 0, return to IDLE.
REQ-046 branch=1, zero=1 during WAIT -> pcsrc 1; reset asserted in WAIT -> all outputs 0 next cycle and a subsequent ack causes no state change.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request, write enable, address, write data and byte enables are held until dmem_ack.
interface mem_bus_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues aligned loads/stores on the data bus, stalls the pipe
// while an access is outstanding, extends load data and flags misalignment/timeouts.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_writedata,
    input  logic        i_memread,
    input  logic        i_memwrite,
    input  logic [1:0]  i_size,
    input  logic        i_is_unsigned,
    input  logic        i_branch,
    input  logic        i_zero,
    mem_bus_if.master   bus,
    output logic [31:0] o_load_data,
    output logic        o_stall,
    output logic        o_pcsrc,
    output logic        o_misalign_err,
    output logic        o_bus_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_state_next;
    logic        r_req, r_we, r_misalign, r_bus_err;
    logic [31:0] r_addr, r_wdata, r_load;
    logic [3:0]  r_be;
    logic [1:0]  r_off, r_size;
    logic        r_uns, r_is_load;
    logic [CW-1:0] r_cnt;

    logic        w_op, w_legal, w_issue, w_misalign, w_complete, w_abort;
    logic [31:0] w_store_data, w_load_ext;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_op    = i_memread | i_memwrite;
    assign w_legal = w_op && ((i_size == 2'b00) ||
                              (i_size == 2'b01 && !i_alu_result[0]) ||
                              (i_size == 2'b10 && i_alu_result[1:0] == 2'b00));
    assign o_pcsrc = i_branch & i_zero;

    // Per-lane store data replication and byte enables; loads always read the full word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_store_data[8*gi +: 8] =
            (i_size == 2'b00) ? i_writedata[7:0] :
            (i_size == 2'b01) ? i_writedata[8*(gi%2) +: 8] :
                                i_writedata[8*gi +: 8];
        assign w_be[gi] =
            i_memread          ? 1'b1 :
            (i_size == 2'b00)  ? (i_alu_result[1:0] == 2'(gi)) :
            (i_size == 2'b01)  ? (i_alu_result[1] == 1'(gi/2)) :
                                 1'b1;
    end

    assign w_byte = bus.dmem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    always_comb begin
        w_load_ext = bus.dmem_rdata;
        case (r_size)
            2'b00:   w_load_ext = {{24{w_byte[7] & ~r_uns}}, w_byte};
            2'b01:   w_load_ext = {{16{w_half[15] & ~r_uns}}, w_half};
            default: w_load_ext = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_misalign   = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        o_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_legal) begin
                    w_issue      = 1'b1;
                    o_stall      = 1'b1;
                    w_state_next = S_WAIT;
                end else if (w_op) begin
                    w_misalign   = 1'b1;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                // An ack arriving on the last allowed cycle still completes normally.
                if (bus.dmem_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = S_DONE;
                end else if (TIMEOUT > 0 && r_cnt == CNT_LAST) begin
                    w_abort      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_load     <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            r_off      <= '0;
            r_size     <= '0;
            r_uns      <= 1'b0;
            r_is_load  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_misalign <= w_misalign;
            r_bus_err  <= w_abort;
            if (w_issue) begin
                r_req     <= 1'b1;
                r_we      <= i_memwrite;
                r_addr    <= {i_alu_result[31:2], 2'b00};
                r_wdata   <= w_store_data;
                r_be      <= w_be;
                r_off     <= i_alu_result[1:0];
                r_size    <= i_size;
                r_uns     <= i_is_unsigned;
                r_is_load <= i_memread;
                r_cnt     <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_complete) begin
                r_req <= 1'b0;
                if (r_is_load) r_load <= w_load_ext;
            end
            if (w_abort) begin
                r_req  <= 1'b0;
                r_load <= '0;
            end
        end
    end

    assign bus.dmem_req   = r_req;
    assign bus.dmem_we    = r_we;
    assign bus.dmem_addr  = r_addr;
    assign bus.dmem_wdata = r_wdata;
    assign bus.dmem_be    = r_be;
    assign o_load_data    = r_load;
    assign o_misalign_err = r_misalign;
    assign o_bus_err      = r_bus_err;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single load/store vectors run back to back,
// then hand sequences for timeout, branch select and reset during WAIT.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] alu_result = '0, writedata = '0;
    logic        memread = 1'b0, memwrite = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        is_unsigned = 1'b0, branch = 1'b0, zero = 1'b0;
    logic [31:0] load_data;
    logic        stall, pcsrc, misalign_err, bus_err;

    mem_bus_if bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_alu_result   (alu_result),
        .i_writedata    (writedata),
        .i_memread      (memread),
        .i_memwrite     (memwrite),
        .i_size         (size),
        .i_is_unsigned  (is_unsigned),
        .i_branch       (branch),
        .i_zero         (zero),
        .bus            (bus),
        .o_load_data    (load_data),
        .o_stall        (stall),
        .o_pcsrc        (pcsrc),
        .o_misalign_err (misalign_err),
        .o_bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        logic        bad;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_load;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_load = '0;
    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        memread = 1'b0; memwrite = 1'b0; alu_result = '0; writedata = '0;
        size = 2'b00; is_unsigned = 1'b0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        memread = rd; memwrite = wr; size = sz; is_unsigned = uns;
        alu_result = addr; writedata = wd;
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at a negedge in IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        int stall_cnt;
        chk("idle_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("idle_misalign", {31'b0, misalign_err}, 32'd0);
        drive_op(v.rd, v.wr, v.sz, v.uns, v.addr, v.wdata);
        #1;
        if (v.bad) begin
            chk("bad_stall", {31'b0, stall}, 32'd0);
            @(posedge clk); @(negedge clk);
            chk("misalign_pulse", {31'b0, misalign_err}, 32'd1);
            chk("bad_req", {31'b0, bus.dmem_req}, 32'd0);
            clear_inputs();
            @(posedge clk); @(negedge clk);
            chk("misalign_clear", {31'b0, misalign_err}, 32'd0);
            chk("bad_req2", {31'b0, bus.dmem_req}, 32'd0);
            $display("[TB] vec %0d misaligned addr=%h size=%0d", idx, v.addr, v.sz);
            return;
        end
        chk("issue_stall", {31'b0, stall}, 32'd1);
        stall_cnt = 1;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k <= v.ack_dly; k++) begin
            chk("wait_req", {31'b0, bus.dmem_req}, 32'd1);
            chk("wait_we", {31'b0, bus.dmem_we}, {31'b0, v.wr});
            chk("wait_be", {28'b0, bus.dmem_be}, {28'b0, v.exp_be});
            chk("wait_addr", bus.dmem_addr, v.exp_addr);
            chk("wait_wdata", bus.dmem_wdata, v.exp_wdata);
            if (stall) stall_cnt++;
            if (k == v.ack_dly) begin
                bus.dmem_ack = 1'b1;
                bus.dmem_rdata = v.rdata;
            end
            @(posedge clk); @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h5A5A_A5A5;
        if (v.rd) m_load = v.exp_load;
        chk("done_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("done_stall", {31'b0, stall}, 32'd0);
        chk("load_data", load_data, m_load);
        chk("stall_cycles", stall_cnt, v.ack_dly + 2);
        // Inputs still presented through DONE: must not be reissued.
        @(posedge clk); @(negedge clk);
        clear_inputs();
        $display("[TB] vec %0d %s addr=%h be=%b wdata=%h load=%h", idx, v.rd ? "load" : "store",
                 bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, load_data);
    endtask

    initial begin
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        //            rd    wr    sz     uns   addr          wdata         rdata         dly bad  be       exp_wdata     exp_addr      exp_load
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FF01, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_1000, 32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 1, 1'b0, 4'b1111, 32'h0,        32'h0000_2000, 32'h0000_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h0,        0, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0000_0100, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        32'h1234_8001, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_0010, 32'hFFFF_8001};
        vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_CAFE, 32'h0,        2, 1'b0, 4'b1100, 32'hCAFE_CAFE, 32'h0000_0020, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0030, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0042, 32'h0,        32'h00AB_0000, 2, 1'b0, 4'b1111, 32'h0,        32'h0000_0040, 32'h0000_00AB};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0,        32'h89AB_CDEF, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_0044, 32'h89AB_CDEF};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_1111, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0,         32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_007F, 1, 1'b0, 4'b1111, 32'h0,        32'h0000_0000, 32'h0000_007F};
        vecs[12] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_0012, 32'h0,        0, 1'b0, 4'b1000, 32'h1212_1212, 32'h0000_0000, 32'h0};

        // Reset state
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst_be", {28'b0, bus.dmem_be}, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);

        // pcsrc is purely branch AND zero
        branch = 1'b1; zero = 1'b0; #1;
        chk("pcsrc_b1z0", {31'b0, pcsrc}, 32'd0);
        zero = 1'b1; #1;
        chk("pcsrc_b1z1", {31'b0, pcsrc}, 32'd1);
        branch = 1'b0; zero = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Timeout: no ack for 4 WAIT cycles
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", {31'b0, bus.dmem_req}, 32'd1);
            chk("to_no_err", {31'b0, bus_err}, 32'd0);
            @(posedge clk); @(negedge clk);
        end
        chk("to_req_drop", {31'b0, bus.dmem_req}, 32'd0);
        chk("to_bus_err", {31'b0, bus_err}, 32'd1);
        chk("to_load_zero", load_data, 32'd0);
        chk("to_stall", {31'b0, stall}, 32'd0);
        clear_inputs();
        @(posedge clk); @(negedge clk);
        chk("to_err_clear", {31'b0, bus_err}, 32'd0);
        $display("[TB] timeout bus_err=%b load=%h", bus_err, load_data);
        m_load = '0;

        // Branch in WAIT, then reset during WAIT and a late ack
        run_vec(100, vecs[8]);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0060, 32'h0);
        @(posedge clk); @(negedge clk);
        branch = 1'b1; zero = 1'b1; #1;
        chk("wait_pcsrc", {31'b0, pcsrc}, 32'd1);
        chk("wait_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1;
        clear_inputs();
        branch = 1'b0; zero = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wrst_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("wrst_we", {31'b0, bus.dmem_we}, 32'd0);
        chk("wrst_addr", bus.dmem_addr, 32'd0);
        chk("wrst_wdata", bus.dmem_wdata, 32'd0);
        chk("wrst_be", {28'b0, bus.dmem_be}, 32'd0);
        chk("wrst_load", load_data, 32'd0);
        chk("wrst_stall", {31'b0, stall}, 32'd0);
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        bus.dmem_ack = 1'b0;
        chk("late_ack_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("late_ack_load", load_data, 32'd0);
        chk("late_ack_stall", {31'b0, stall}, 32'd0);
        $display("[TB] reset in WAIT req=%b load=%h", bus.dmem_req, load_data);
        m_load = '0;
        run_vec(101, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
